op_link_rst_ctrl: RTL

Parametrised multi-channel optical-link reset sequencer. It replaces the fixed two-channel DAQ/TRG transmitter-disable FSM. Start-up and per-channel reset requests are turned into a fixed-length TX-disable pulse on the requesting channels. A cool-down holdoff follows each pulse, and the block waits for all requests to drop before it re-arms. An optional triplicated (TMR) build is available for the radiation environment of the front-end board.

---
 rtl/op_link_rst_pkg.sv | 23 ++
 rtl/op_link_rst_ctrl_tmr_vote3.sv | 15 +
 rtl/op_link_rst_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/op_link_rst_pkg.sv
// rtl/op_link_rst_pkg.sv - shared types, constants and majority helper for the optical-link reset sequencer
package op_link_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TX_DIS = 2'b01,
        ST_HOLD   = 2'b10,
        ST_WAIT   = 2'b11
    } state_t;

    localparam int RST_CNT_W = 8;
    localparam int MAJ_W     = 64;

    // Callers zero-extend narrower vectors and truncate the result back.
    function automatic logic [MAJ_W-1:0] maj3(
        input logic [MAJ_W-1:0] a,
        input logic [MAJ_W-1:0] b,
        input logic [MAJ_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/op_link_rst_ctrl_tmr_vote3.sv
// rtl/op_link_rst_ctrl_tmr_vote3.sv - parametrised 3-input bitwise majority voter (module tmr_vote3)
module tmr_vote3
    import op_link_rst_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = W'(maj3(MAJ_W'(a), MAJ_W'(b), MAJ_W'(c)));

endmodule

// File: rtl/op_link_rst_ctrl.sv
// rtl/op_link_rst_ctrl.sv - multi-channel TX-disable reset sequencer; OP_LINK_RST_TMR_EN builds a triplicated core
module op_link_rst_ctrl
    import op_link_rst_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int CNT_W     = 12,
    parameter int PULSE_DUR = 4000,
    parameter int HOLDOFF   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 STRTUP_OP_RST,
    input  logic [NCH-1:0]       OP_RST,
    output logic [NCH-1:0]       TDIS,
    output logic                 BUSY,
    output logic [RST_CNT_W-1:0] RST_CNT
);

    if (NCH < 1 || NCH > 8) begin : g_chk_nch
        $fatal(1, "op_link_rst_ctrl: NCH out of range 1..8");
    end
    if (PULSE_DUR < 1) begin : g_chk_pd_min
        $fatal(1, "op_link_rst_ctrl: PULSE_DUR must be at least 1");
    end
    if (PULSE_DUR >= (1 << CNT_W)) begin : g_chk_pd_max
        $fatal(1, "op_link_rst_ctrl: PULSE_DUR does not fit in CNT_W");
    end
    if (HOLDOFF < 0 || HOLDOFF >= (1 << CNT_W)) begin : g_chk_ho
        $fatal(1, "op_link_rst_ctrl: HOLDOFF does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] PD_VAL   = CNT_W'(PULSE_DUR);
    localparam logic [CNT_W-1:0] HO_VAL   = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               HAS_HOLD = (HOLDOFF != 0);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NCH-1:0]         mask_q, mask_d;
    logic [RST_CNT_W-1:0]   rcnt_q, rcnt_d;
    logic                   req;
    logic [NCH-1:0]         chreq;

    assign req   = STRTUP_OP_RST | (|OP_RST);
    assign chreq = {NCH{STRTUP_OP_RST}} | OP_RST;

    // mask is only non-zero in Tx_Dis, so it doubles as the registered TDIS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_TX_DIS;
                    mask_d  = chreq;
                    cnt_d   = CNT_ONE;
                    if (rcnt_q != {RST_CNT_W{1'b1}}) rcnt_d = rcnt_q + RST_CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_TX_DIS: begin
                mask_d = mask_q | chreq;
                if (cnt_q == PD_VAL) begin
                    state_d = HAS_HOLD ? ST_HOLD : ST_WAIT;
                    mask_d  = '0;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HO_VAL) state_d = ST_WAIT;
                else                 cnt_d   = cnt_q + CNT_ONE;
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                mask_d  = '0;
            end
        endcase
    end

`ifdef OP_LINK_RST_TMR_EN
    (* preserve = 1, keep = 1 *) logic [1:0]           state_r [3];
    (* preserve = 1, keep = 1 *) logic [CNT_W-1:0]     cnt_r   [3];
    (* preserve = 1, keep = 1 *) logic [NCH-1:0]       mask_r  [3];
    (* preserve = 1, keep = 1 *) logic [RST_CNT_W-1:0] rcnt_r  [3];
    logic [1:0] state_v;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= '0;
                mask_r[i]  <= '0;
                rcnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= state_d;
                cnt_r[i]   <= cnt_d;
                mask_r[i]  <= mask_d;
                rcnt_r[i]  <= rcnt_d;
            end
        end
    end

    tmr_vote3 #(.W(2))         u_vote_state (.a(state_r[0]), .b(state_r[1]), .c(state_r[2]), .y(state_v));
    tmr_vote3 #(.W(CNT_W))     u_vote_cnt   (.a(cnt_r[0]),   .b(cnt_r[1]),   .c(cnt_r[2]),   .y(cnt_q));
    tmr_vote3 #(.W(NCH))       u_vote_mask  (.a(mask_r[0]),  .b(mask_r[1]),  .c(mask_r[2]),  .y(mask_q));
    tmr_vote3 #(.W(RST_CNT_W)) u_vote_rcnt  (.a(rcnt_r[0]),  .b(rcnt_r[1]),  .c(rcnt_r[2]),  .y(rcnt_q));

    assign state_q = state_t'(state_v);
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            rcnt_q  <= rcnt_d;
        end
    end
`endif

    assign TDIS    = mask_q;
    assign BUSY    = (state_q != ST_IDLE);
    assign RST_CNT = rcnt_q;

endmodule
